matrix_input_parser: RTL and testbench
======================================

MATRIX_INPUT_PARSER -- requirements
Module: matrix_input_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100_000_000: maximum idle cycles between received bytes while busy; 0 disables the timeout.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that begins parsing one matrix.
REQ-005 matrix_row  input  3  row count, valid range 1..5.
REQ-006 matrix_col  input  3  column count, valid range 1..5.
REQ-007 rx_data  input  8  received UART byte, valid only while rx_valid=1.
REQ-008 rx_valid  input  1  one-cycle strobe for each received byte.
REQ-009 busy  output  1  high while a parse is in progress.
REQ-010 wr_en  output  1  one-cycle element write strobe to storage.
REQ-011 wr_addr  output  5  row-major element index, r*matrix_col+c.
REQ-012 wr_data  output  8  parsed element value, 0..255.
REQ-013 done  output  1  one-cycle pulse after the final element write.
REQ-014 error  output  1  one-cycle pulse when a parse aborts.
REQ-015 error_code  output  2  abort cause: 0 none, 1 illegal char, 2 overflow, 3 timeout; held until next accepted start.

Function
REQ-016 States SHALL be IDLE, SEP (waiting for a digit, separators skipped), NUM (accumulating digits), WRITE, DONE, ERR.
REQ-017 In IDLE, start with row and col in 1..5 SHALL latch row/col, clear r/c counters, accumulator and error_code, set busy=1 next cycle, and enter SEP.
REQ-018 A start with row or col equal to 0 or greater than 5 SHALL be ignored; a start while busy=1 SHALL be ignored.
REQ-019 Digit bytes 0x30..0x39 SHALL update acc = acc*10 + (byte-0x30); the first digit in SEP SHALL load acc = digit and move to NUM.
REQ-020 Separator bytes are 0x20, 0x0A and 0x0D; in SEP they SHALL be ignored, including any number of consecutive separators.
REQ-021 A separator in NUM SHALL move to WRITE; wr_en=1, wr_addr=r*col+c and wr_data=acc SHALL appear in the cycle after that separator's rx_valid.
REQ-022 After WRITE, c SHALL increment; at c=col-1, c SHALL wrap to 0 and r SHALL increment; after the write of index row*col-1 the FSM SHALL enter DONE, otherwise SEP.
REQ-023 DONE SHALL assert done=1 and busy=0 for exactly one cycle, one cycle after the last wr_en, then return to IDLE.
REQ-024 Row/column placement SHALL follow element order only; line breaks SHALL NOT be checked against matrix_col.
REQ-025 A byte other than a digit or separator while busy SHALL abort with error_code=1.
REQ-026 A digit that makes the intermediate acc exceed 255 SHALL abort with error_code=2; the accumulator SHALL be at least 12 bits wide to detect this.
REQ-027 If TIMEOUT_CYCLES is nonzero and TIMEOUT_CYCLES cycles pass with busy=1 and no rx_valid, the block SHALL abort with error_code=3; the counter SHALL reset on every rx_valid.
REQ-028 On abort the block SHALL enter ERR and assert error=1 for one cycle, one cycle after the offending byte or timeout; in that same cycle busy SHALL be 0 and no wr_en SHALL occur; the block then returns to IDLE.
REQ-029 Elements already written before an abort SHALL NOT be retracted.
REQ-030 rx_valid while in IDLE, WRITE, DONE or ERR SHALL be dropped; the upstream UART provides at least 2 cycles between strobes.
REQ-031 A digit with no terminating separator SHALL never be written.

Reset
REQ-032 On rst_n=0 the state SHALL be IDLE; busy, wr_en, done and error SHALL be 0; wr_addr, wr_data, error_code, counters and acc SHALL be 0, even mid-parse.
REQ-033 No wr_en or done SHALL occur during or in the cycle after reset release.

Verification
REQ-034 2x2, bytes "1 2\n3 4\n" -> writes (0,1),(1,2),(2,3),(3,4); done pulses once, one cycle after the last write.
REQ-035 1x3, bytes "  255\r\n07   10\n" -> writes (0,255),(1,7),(2,10); done pulses.
REQ-036 1x1, bytes "256 " -> error pulse with error_code=2 one cycle after byte '6'; no wr_en; busy=0.
REQ-037 2x2, bytes "1 x" -> one write (0,1), then error_code=1 and error pulse; no done.
REQ-038 TIMEOUT_CYCLES=50, 1x2, bytes "5 " then silence -> write (0,5), then error_code=3 exactly 50 cycles after the last rx_valid.
REQ-039 rst_n asserted mid-parse of a 3x3 -> all outputs 0 immediately; a fresh start afterwards parses correctly from index 0; start with row=0 -> busy stays 0.

Source files
------------

// File: rtl/matrix_input_parser.sv
// matrix_input_parser: turns an ASCII decimal UART byte stream into row-major matrix element writes
module matrix_input_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] matrix_row,
   input  logic [2:0] matrix_col,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       busy,
   output logic       wr_en,
   output logic [4:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       done,
   output logic       error,
   output logic [1:0] error_code
);
   typedef enum logic [2:0] {IDLE, SEP, NUM, WRITE, DONE, ERR} state_t;
   state_t state_q, state_d;
   logic [2:0] row_q, row_d, col_q, col_d, r_q, r_d, c_q, c_d;
   logic [4:0] idx_q, idx_d;
   logic [11:0] acc_q, acc_d, acc_mul;
   logic [1:0] code_q, code_d;
   logic [31:0] tmo_q, tmo_d;
   logic is_digit, is_sep, dims_ok, timeout, col_end, last;
   assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
   assign is_sep = rx_data == 8'h20 || rx_data == 8'h0a || rx_data == 8'h0d;
   assign dims_ok = matrix_row != 3'd0 && matrix_row <= 3'd5 && matrix_col != 3'd0 && matrix_col <= 3'd5;
   assign acc_mul = acc_q * 12'd10 + {8'd0, rx_data[3:0]};
   assign timeout = TIMEOUT_CYCLES != 0 && !rx_valid && tmo_q >= 32'(TIMEOUT_CYCLES - 1);
   assign col_end = c_q == col_q - 3'd1;
   assign last = col_end && r_q == row_q - 3'd1;
   assign busy = state_q == SEP || state_q == NUM || state_q == WRITE;
   assign wr_en = state_q == WRITE;
   assign done = state_q == DONE;
   assign error = state_q == ERR;
   assign wr_addr = idx_q;
   assign wr_data = acc_q[7:0];
   assign error_code = code_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q <= 3'd0;
         col_q <= 3'd0;
         r_q <= 3'd0;
         c_q <= 3'd0;
         idx_q <= 5'd0;
         acc_q <= 12'd0;
         code_q <= 2'd0;
         tmo_q <= 32'd0;
      end else begin
         state_q <= state_d;
         row_q <= row_d;
         col_q <= col_d;
         r_q <= r_d;
         c_q <= c_d;
         idx_q <= idx_d;
         acc_q <= acc_d;
         code_q <= code_d;
         tmo_q <= tmo_d;
      end
   end
   always_comb begin
      state_d = state_q;
      row_d = row_q;
      col_d = col_q;
      r_d = r_q;
      c_d = c_q;
      idx_d = idx_q;
      acc_d = acc_q;
      code_d = code_q;
      tmo_d = (busy && !rx_valid) ? tmo_q + 32'd1 : 32'd0;
      case (state_q)
         IDLE: if (start && dims_ok) begin
            state_d = SEP;
            row_d = matrix_row;
            col_d = matrix_col;
            r_d = 3'd0;
            c_d = 3'd0;
            idx_d = 5'd0;
            acc_d = 12'd0;
            code_d = 2'd0;
         end
         SEP: if (rx_valid) begin
            if (is_digit) begin
               acc_d = {8'd0, rx_data[3:0]};
               state_d = NUM;
            end else if (!is_sep) begin
               code_d = 2'd1;
               state_d = ERR;
            end
         end else if (timeout) begin
            code_d = 2'd3;
            state_d = ERR;
         end
         NUM: if (rx_valid) begin
            if (is_sep) state_d = WRITE;
            else if (!is_digit) begin
               code_d = 2'd1;
               state_d = ERR;
            end else if (acc_mul > 12'd255) begin
               code_d = 2'd2;
               state_d = ERR;
            end else acc_d = acc_mul;
         end else if (timeout) begin
            code_d = 2'd3;
            state_d = ERR;
         end
         WRITE: begin
            idx_d = idx_q + 5'd1;
            c_d = col_end ? 3'd0 : c_q + 3'd1;
            r_d = col_end ? r_q + 3'd1 : r_q;
            state_d = last ? DONE : SEP;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_matrix_input_parser.sv
// tb_matrix_input_parser: table-driven byte-stream vectors plus reset, ignored-start and timing sequences
module tb_matrix_input_parser;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
   logic [2:0] matrix_row = 3'd0, matrix_col = 3'd0;
   logic [7:0] rx_data = 8'd0;
   logic busy, wr_en, done, error;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic [1:0] error_code;
   matrix_input_parser #(.TIMEOUT_CYCLES(50)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .matrix_row(matrix_row), .matrix_col(matrix_col),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .done(done), .error(error), .error_code(error_code)
   );
   always #5 clk = ~clk;
   typedef struct {
      int row; int col; int len; logic [511:0] bytes;
      int nw; logic [199:0] data; int exp_done; int code; int gap;
   } vec_t;
   vec_t vecs[11];
   int n_pass = 0, n_tot = 0;
   int cyc = 0, rx_cyc = 0, last_wr = 0, nwr = 0, ndone = 0, nerr = 0;
   int done_gap = 0, err_gap = 0, lat_bad = 0, err_bad = 0;
   logic [4:0] wa[128];
   logic [7:0] wd[128];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (rx_valid) rx_cyc <= cyc;
      if (wr_en) begin
         wa[nwr] <= wr_addr;
         wd[nwr] <= wr_data;
         nwr <= nwr + 1;
         last_wr <= cyc;
         if (cyc - rx_cyc != 1) lat_bad <= lat_bad + 1;
      end
      if (done) begin
         ndone <= ndone + 1;
         done_gap <= cyc - last_wr;
      end
      if (error) begin
         nerr <= nerr + 1;
         err_gap <= cyc - rx_cyc;
         if (busy || wr_en) err_bad <= err_bad + 1;
      end
   end
   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask
   task automatic send(input logic [7:0] b);
      @(posedge clk); #1 rx_data = b; rx_valid = 1'b1;
      @(posedge clk); #1 rx_valid = 1'b0;
      repeat (2) @(posedge clk);
   endtask
   task automatic pulse_start(input int r, input int c);
      @(posedge clk); #1 matrix_row = 3'(r); matrix_col = 3'(c); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask
   task automatic run(input string tag, input vec_t v);
      int b0, d0, e0;
      b0 = nwr; d0 = ndone; e0 = nerr;
      pulse_start(v.row, v.col);
      @(negedge clk); chk({tag, " busy after start"}, int'(busy), 1);
      for (int i = 0; i < v.len; i++) send(v.bytes[8*(v.len-1-i) +: 8]);
      repeat (60) @(posedge clk);
      @(negedge clk);
      chk({tag, " write count"}, nwr - b0, v.nw);
      for (int k = 0; k < v.nw; k++) begin
         chk($sformatf("%s wr%0d addr", tag, k), int'(wa[b0+k]), k);
         chk($sformatf("%s wr%0d data", tag, k), int'(wd[b0+k]), int'(v.data[8*k +: 8]));
      end
      chk({tag, " done count"}, ndone - d0, v.exp_done);
      chk({tag, " error count"}, nerr - e0, v.code != 0 ? 1 : 0);
      chk({tag, " error_code"}, int'(error_code), v.code);
      chk({tag, " busy at end"}, int'(busy), 0);
      if (v.exp_done != 0) chk({tag, " done latency"}, done_gap, v.gap);
      else chk({tag, " error latency"}, err_gap, v.gap);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end
   initial begin
      vec_t v;
      int b0, d0;
      vecs[0] = '{2, 2, 8, 512'("1 2\n3 4\n"), 4, 200'({8'd4, 8'd3, 8'd2, 8'd1}), 1, 0, 1};
      vecs[1] = '{1, 3, 15, 512'("  255\015\n07   10\n"), 3, 200'({8'd10, 8'd7, 8'd255}), 1, 0, 1};
      vecs[2] = '{1, 1, 4, 512'("256 "), 0, 200'd0, 0, 2, 1};
      vecs[3] = '{2, 2, 3, 512'("1 x"), 1, 200'({8'd1}), 0, 1, 1};
      vecs[4] = '{3, 1, 11, 512'("12\n\n 0\n200\n"), 3, 200'({8'd200, 8'd0, 8'd12}), 1, 0, 1};
      vecs[5] = '{2, 3, 12, 512'("1 2 3 4 5 6 "), 6, 200'({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}), 1, 0, 1};
      vecs[6] = '{1, 2, 4, 512'("7\0158!"), 1, 200'({8'd7}), 0, 1, 1};
      vecs[7] = '{1, 1, 2, 512'("99"), 0, 200'd0, 0, 3, 51};
      vecs[8] = '{5, 5, 50, 512'({25{16'h3120}}), 25, 200'({25{8'd1}}), 1, 0, 1};
      vecs[9] = '{1, 2, 2, 512'("5 "), 1, 200'({8'd5}), 0, 3, 51};
      vecs[10] = '{1, 1, 5, 512'("2550 "), 0, 200'd0, 0, 2, 1};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset busy/wr_en/done/error", int'({busy, wr_en, done, error}), 0);
      chk("reset wr_addr", int'(wr_addr), 0);
      chk("reset wr_data", int'(wr_data), 0);
      chk("reset error_code", int'(error_code), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 11; i++) run($sformatf("v%0d", i), vecs[i]);
      pulse_start(3, 3);
      send("1"); send(" "); send("2"); send(" "); send("3");
      @(negedge clk);
      chk("mid-parse wr_addr before reset", int'(wr_addr), 2);
      #1 rst_n = 1'b0;
      #1;
      chk("mid-parse reset busy/wr_en/done/error", int'({busy, wr_en, done, error}), 0);
      chk("mid-parse reset wr_addr", int'(wr_addr), 0);
      chk("mid-parse reset wr_data", int'(wr_data), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("after release cycle %0d wr_en/done", i), int'({wr_en, done}), 0);
      end
      v = '{1, 2, 4, 512'("8 9 "), 2, 200'({8'd9, 8'd8}), 1, 0, 1};
      run("post-reset", v);
      for (int i = 0; i < 4; i++) begin
         pulse_start(i == 0 ? 0 : i == 1 ? 2 : i == 2 ? 2 : 7, i == 0 ? 2 : i == 1 ? 0 : i == 2 ? 6 : 3);
         repeat (2) @(negedge clk);
         chk($sformatf("bad dims start %0d busy", i), int'(busy), 0);
      end
      b0 = nwr; d0 = ndone;
      pulse_start(1, 2);
      send("4");
      pulse_start(3, 3);
      send(" "); send("6"); send(" ");
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("start while busy write count", nwr - b0, 2);
      chk("start while busy wr0 data", int'(wd[b0]), 4);
      chk("start while busy wr1 addr", int'(wa[b0+1]), 1);
      chk("start while busy wr1 data", int'(wd[b0+1]), 6);
      chk("start while busy done count", ndone - d0, 1);
      chk("write latency violations", lat_bad, 0);
      chk("busy/wr_en during error", err_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
